// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 32-byte lines between the core port and pmem.
// Optional hit/miss counters are enabled by defining L1_CACHE_PERF_EN.
module l1_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L1_CACHE_PERF_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int TAG_W = 27 - S_INDEX;
  localparam int SETS  = 1 << S_INDEX;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

  state_t             state;
  logic [TAG_W-1:0]   tag_r;
  logic [S_INDEX-1:0] idx_r;
  logic [2:0]         word_r;
  logic               we_r;
  logic [3:0]         be_r;
  logic [31:0]        wdata_r;
`ifdef L1_CACHE_PERF_EN
  logic               miss_seen_r;
`endif

  logic               valid_r  [SETS];
  logic               dirty_r  [SETS];
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [255:0]       line_mem [SETS];

  logic [TAG_W-1:0]   req_tag_s;
  logic [S_INDEX-1:0] req_idx_s;
  logic               req_hit_s;
  logic [31:0]        req_word_s;
  logic               fill_we_s;
  logic               wr_hit_s;
  logic               unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  // Lookup of the incoming request so the hit response can be registered on the IDLE->CHECK edge
  always_comb begin
    req_tag_s  = mem_address[31:5+S_INDEX];
    req_idx_s  = mem_address[4+S_INDEX:5];
    req_hit_s  = valid_r[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s);
    req_word_s = line_mem[req_idx_s][{mem_address[4:2], 5'd0} +: 32];
    fill_we_s  = (state == FILL) && pmem_resp;
    wr_hit_s   = (state == CHECK) && mem_resp && we_r;
    unused_s   = ^mem_address[1:0];
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_resp     <= 1'b0;
      mem_rdata    <= 32'd0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= 32'd0;
      pmem_wdata   <= 256'd0;
      tag_r        <= '0;
      idx_r        <= '0;
      word_r       <= 3'd0;
      we_r         <= 1'b0;
      be_r         <= 4'd0;
      wdata_r      <= 32'd0;
`ifdef L1_CACHE_PERF_EN
      miss_seen_r  <= 1'b0;
      hit_count    <= 32'd0;
      miss_count   <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_resp <= 1'b0;
          if (mem_read || mem_write) begin
            tag_r    <= req_tag_s;
            idx_r    <= req_idx_s;
            word_r   <= mem_address[4:2];
            we_r     <= mem_write;
            be_r     <= mem_byte_enable;
            wdata_r  <= mem_wdata;
            mem_resp <= req_hit_s;
            if (req_hit_s) begin
              mem_rdata <= req_word_s;
            end
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mem_resp) begin
            mem_resp <= 1'b0;
            state    <= IDLE;
`ifdef L1_CACHE_PERF_EN
            miss_seen_r <= 1'b0;
            if (miss_seen_r) begin
              miss_count <= miss_count + 32'd1;
            end else begin
              hit_count <= hit_count + 32'd1;
            end
`endif
          end else begin
`ifdef L1_CACHE_PERF_EN
            miss_seen_r <= 1'b1;
`endif
            if (valid_r[idx_r] && dirty_r[idx_r]) begin
              pmem_write   <= 1'b1;
              pmem_address <= {tag_mem[idx_r], idx_r, 5'd0};
              pmem_wdata   <= line_mem[idx_r];
              state        <= WB;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {tag_r, idx_r, 5'd0};
              state        <= FILL;
            end
          end
        end
        WB: begin
          if (pmem_resp) begin
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {tag_r, idx_r, 5'd0};
            state        <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            mem_resp  <= 1'b1;
            mem_rdata <= pmem_rdata[{word_r, 5'd0} +: 32];
            state     <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and line storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      line_mem[idx_r] <= pmem_rdata;
      tag_mem[idx_r]  <= tag_r;
    end else if (wr_hit_s) begin
      line_mem[idx_r][{word_r, 5'd0} +: 32] <=
        merge_bytes(line_mem[idx_r][{word_r, 5'd0} +: 32], wdata_r, be_r);
    end
  end

  // Valid and dirty state per set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid_r[i] <= 1'b0;
        dirty_r[i] <= 1'b0;
      end
    end else if (fill_we_s) begin
      valid_r[idx_r] <= 1'b1;
      dirty_r[idx_r] <= 1'b0;
    end else if (wr_hit_s) begin
      dirty_r[idx_r] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: vector table of core requests against a behavioural line memory,
// plus hand sequences for write-back contents, long fill latency and reset during a fill.
module tb_l1_cache;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef L1_CACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  l1_cache #(.S_INDEX(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
`ifdef L1_CACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [255:0] mem [logic [31:0]];
  int           lat = 0;
  logic         hold = 1'b0;
  int           n_reads = 0;
  int           n_writes = 0;
  int           n_resp = 0;
  int           n_bad = 0;
  logic [31:0]  rd_addr_q [$];
  logic [31:0]  wr_addr_q [$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cycles;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [255:0] dflt_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(4 * i);
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt_line(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural line memory answering pmem requests after lat idle cycles
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !hold && rst_n) begin
        if (cnt >= lat) begin
          pmem_resp = 1'b1;
          cnt = 0;
          if (pmem_read) begin
            pmem_rdata = mem_line(pmem_address);
            rd_addr_q.push_back(pmem_address);
            n_reads++;
          end else begin
            mem[pmem_address] = pmem_wdata;
            wr_addr_q.push_back(pmem_address);
            n_writes++;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Protocol monitor: response pulses and forbidden overlaps
  initial begin
    forever begin
      @(negedge clk);
      if (mem_resp) n_resp++;
      if (pmem_read && pmem_write) n_bad++;
      if (mem_resp && (pmem_read || pmem_write)) n_bad++;
      if ((pmem_read || pmem_write) && (pmem_address[4:0] != 5'd0)) n_bad++;
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata, output int cycles);
    logic got;
    got = 1'b0;
    rdata = 32'd0;
    cycles = 0;
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_byte_enable = be;
    mem_wdata = wd;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mem_resp) begin
        got = 1'b1;
        rdata = mem_rdata;
      end
    end
    if (!got) begin
      total++;
      $display("FAIL timeout: no mem_resp for address %h after %0d cycles", addr, cycles);
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0]  rdata;
    logic [255:0] line;
    int           cyc;
    int           r0;
    int           w0;
    int           p0;

    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'd0;
    mem_byte_enable = 4'd0;
    mem_wdata = 32'd0;
    rst_n = 1'b0;

    line = dflt_line(32'h40);
    line[63:32] = 32'hDEAD_BEEF;
    mem[32'h40] = line;

    vecs[0]  = '{1'b1, 1'b0, 32'h44,  4'h0, 32'h0,         32'hDEAD_BEEF, 3, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h44,  4'h0, 32'h0,         32'hDEAD_BEEF, 1, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 32'h44,  4'h3, 32'h1234_5678, 32'h0,         1, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'h44,  4'h0, 32'h0,         32'hDEAD_5678, 1, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h144, 4'h0, 32'h0,         32'h0000_0144, 4, 1, 1};
    vecs[5]  = '{1'b1, 1'b0, 32'h48,  4'h0, 32'h0,         32'h0000_0048, 3, 1, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'h64,  4'hF, 32'hA5A5_A5A5, 32'h0,         3, 1, 0};
    vecs[7]  = '{1'b1, 1'b0, 32'h64,  4'h0, 32'h0,         32'hA5A5_A5A5, 1, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 32'h60,  4'h0, 32'h0,         32'h0000_0060, 1, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 32'h68,  4'h8, 32'h77AA_BBCC, 32'h0,         1, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h68,  4'h0, 32'h0,         32'h7700_0068, 1, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 32'h364, 4'h0, 32'h0,         32'h0000_0364, 4, 1, 1};

    repeat (2) @(negedge clk);
    chk("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_pmem_req", {30'd0, pmem_read, pmem_write}, 32'd0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    chk("rst_pmem_wdata", {31'd0, |pmem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      r0 = n_reads;
      w0 = n_writes;
      p0 = n_resp;
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata, rdata, cyc);
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      chk($sformatf("v%0d_fills", i), 32'(n_reads - r0), 32'(vecs[i].exp_reads));
      chk($sformatf("v%0d_writebacks", i), 32'(n_writes - w0), 32'(vecs[i].exp_writes));
      chk($sformatf("v%0d_resp_pulses", i), 32'(n_resp - p0), 32'd1);
    end

    line = mem_line(32'h40);
    chk("wb40_word1", line[63:32], 32'hDEAD_5678);
    chk("wb40_word2", line[95:64], 32'h0000_0048);
    line = mem_line(32'h60);
    chk("wb60_word1", line[63:32], 32'hA5A5_A5A5);
    chk("wb60_word2", line[95:64], 32'h7700_0068);
    chk("wb_count", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("wb0_addr", wr_addr_q[0], 32'h40);
      chk("wb1_addr", wr_addr_q[1], 32'h60);
    end
    chk("fill_count", 32'(rd_addr_q.size()), 32'd5);
    if (rd_addr_q.size() == 5) begin
      chk("fill0_addr", rd_addr_q[0], 32'h40);
      chk("fill1_addr", rd_addr_q[1], 32'h140);
      chk("fill4_addr", rd_addr_q[4], 32'h360);
    end

    // Long fill latency: a single response, exactly 3 + latency cycles after the request
    lat = 20;
    p0 = n_resp;
    do_req(1'b1, 1'b0, 32'h84, 4'h0, 32'h0, rdata, cyc);
    chk("slow_rdata", rdata, 32'h0000_0084);
    chk("slow_cycles", 32'(cyc), 32'd23);
    chk("slow_resp_pulses", 32'(n_resp - p0), 32'd1);
    lat = 0;

    // Reset asserted while a fill is outstanding
    hold = 1'b1;
    mem_read = 1'b1;
    mem_address = 32'h1A4;
    repeat (4) @(negedge clk);
    chk("fill_pending", {31'd0, pmem_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drops_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_drops_mem_resp", {31'd0, mem_resp}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    @(negedge clk);
    r0 = n_reads;
    do_req(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rdata, cyc);
    chk("post_rst_rdata", rdata, 32'hDEAD_5678);
    chk("post_rst_cycles", 32'(cyc), 32'd3);
    chk("post_rst_fills", 32'(n_reads - r0), 32'd1);

`ifdef L1_CACHE_PERF_EN
    do_reset();
    chk("perf_rst_hits", hit_count, 32'd0);
    chk("perf_rst_misses", miss_count, 32'd0);
    do_req(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rdata, cyc);
    do_req(1'b0, 1'b1, 32'h44, 4'hF, 32'h0BAD_F00D, rdata, cyc);
    do_req(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rdata, cyc);
    chk("perf_hit_rdata", rdata, 32'h0BAD_F00D);
    do_req(1'b1, 1'b0, 32'h144, 4'h0, 32'h0, rdata, cyc);
    chk("perf_hits", hit_count, 32'd2);
    chk("perf_misses", miss_count, 32'd2);
`endif

    chk("protocol_violations", 32'(n_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
